// File: rtl/simd_seq_pkg.sv
// rtl/simd_seq_pkg.sv - shared opcodes, FSM states, dot_ctrl codes and field layout helpers for simd_seq_engine
package simd_seq_pkg;

  typedef enum logic [2:0] {
    OPC_NOP  = 3'd0,
    OPC_EXEC = 3'd1,
    OPC_DOT  = 3'd2,
    OPC_JUMP = 3'd3,
    OPC_LOOP = 3'd4,
    OPC_ENDL = 3'd5,
    OPC_HALT = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE
  } state_e;

  localparam logic [1:0] DOT_NONE  = 2'b00;
  localparam logic [1:0] DOT_FIRST = 2'b01;
  localparam logic [1:0] DOT_ACC   = 2'b10;
  localparam logic [1:0] DOT_LAST  = 2'b11;

  // Word layout from LSB up: rpt, r, b, a, pe_op, opcode
  function automatic int f_r_lsb(input int rpt_w);
    return rpt_w;
  endfunction

  function automatic int f_b_lsb(input int rpt_w, input int addr_w);
    return rpt_w + addr_w;
  endfunction

  function automatic int f_a_lsb(input int rpt_w, input int addr_w);
    return rpt_w + 2 * addr_w;
  endfunction

  function automatic int f_pe_lsb(input int rpt_w, input int addr_w);
    return rpt_w + 3 * addr_w;
  endfunction

  function automatic int f_opc_lsb(input int rpt_w, input int addr_w, input int op_w);
    return f_pe_lsb(rpt_w, addr_w) + op_w;
  endfunction

endpackage

// File: rtl/seq_ins_mem.sv
// rtl/seq_ins_mem.sv - single-port synchronous instruction RAM with registered read
module seq_ins_mem #(
  parameter int AW = 8,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  // The read register doubles as the instruction register: it only loads on a fetch.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/simd_seq_engine.sv
// rtl/simd_seq_engine.sv - sequencer expanding stored SIMD instructions into per-cycle PE beats
// Hardware loops (LOOP/ENDL) exist only when SEQ_LOOP_EN is defined.
module simd_seq_engine
  import simd_seq_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int OPCODE_WIDTH   = 3,
  parameter int OP_SEL_WIDTH   = 2,
  parameter int RPT_WIDTH      = 8,
  parameter int INS_WIDTH      = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      prog_we,
  input  logic [INS_ADDR_WIDTH-1:0] prog_addr,
  input  logic [INS_WIDTH-1:0]      prog_data,
  input  logic                      start,
  input  logic [INS_ADDR_WIDTH-1:0] start_pc,
  input  logic                      stall,
  output logic [ADDR_WIDTH-1:0]     a_addr,
  output logic [ADDR_WIDTH-1:0]     b_addr,
  output logic [ADDR_WIDTH-1:0]     r_addr,
  output logic [OP_SEL_WIDTH-1:0]   pe_op,
  output logic [1:0]                dot_ctrl,
  output logic                      write_en,
  output logic                      r_select,
  output logic                      valid,
  output logic                      busy,
  output logic                      done
);

  localparam int R_LSB   = f_r_lsb(RPT_WIDTH);
  localparam int B_LSB   = f_b_lsb(RPT_WIDTH, ADDR_WIDTH);
  localparam int A_LSB   = f_a_lsb(RPT_WIDTH, ADDR_WIDTH);
  localparam int PE_LSB  = f_pe_lsb(RPT_WIDTH, ADDR_WIDTH);
  localparam int OPC_LSB = f_opc_lsb(RPT_WIDTH, ADDR_WIDTH, OP_SEL_WIDTH);
  localparam int USED_W  = OPC_LSB + OPCODE_WIDTH;

  state_e                    r_state, w_state_nxt;
  logic [INS_ADDR_WIDTH-1:0] r_pc;
  logic [RPT_WIDTH-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0]     r_a, r_b, r_r;
  logic [OP_SEL_WIDTH-1:0]   r_pe_op;
  logic                      r_done;
`ifdef SEQ_LOOP_EN
  logic [INS_ADDR_WIDTH-1:0] r_loop_start;
  logic [RPT_WIDTH-1:0]      r_loop_cnt;
`endif

  logic [INS_WIDTH-1:0]      w_ins;
  logic [INS_ADDR_WIDTH-1:0] w_mem_addr;
  logic                      w_mem_we, w_mem_re;

  assign w_mem_we   = prog_we && (r_state == S_IDLE);
  assign w_mem_re   = (r_state == S_FETCH) && !stall;
  assign w_mem_addr = (r_state == S_IDLE) ? prog_addr : r_pc;

  seq_ins_mem #(.AW(INS_ADDR_WIDTH), .DW(INS_WIDTH)) u_ins_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_mem_addr),
    .i_wdata (prog_data),
    .o_rdata (w_ins)
  );

  logic [OPCODE_WIDTH-1:0] w_opc;
  logic [RPT_WIDTH-1:0]    w_rpt;
  logic                    w_is_exec, w_is_dot, w_is_jump, w_is_halt;

  assign w_opc     = w_ins[OPC_LSB +: OPCODE_WIDTH];
  assign w_rpt     = w_ins[RPT_WIDTH-1:0];
  assign w_is_exec = (w_opc == OPCODE_WIDTH'(OPC_EXEC));
  assign w_is_dot  = (w_opc == OPCODE_WIDTH'(OPC_DOT));
  assign w_is_jump = (w_opc == OPCODE_WIDTH'(OPC_JUMP));
  assign w_is_halt = (w_opc == OPCODE_WIDTH'(OPC_HALT));

  generate
    if (INS_WIDTH > USED_W) begin : g_pad
      logic w_unused_hi;
      assign w_unused_hi = ^w_ins[INS_WIDTH-1:USED_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!stall) begin
      case (r_state)
        S_IDLE:   if (start) w_state_nxt = S_FETCH;
        S_FETCH:  w_state_nxt = S_DECODE;
        S_DECODE: begin
          if (w_is_exec || w_is_dot) w_state_nxt = S_ISSUE;
          else if (w_is_halt)        w_state_nxt = S_IDLE;
          else                       w_state_nxt = S_FETCH;
        end
        S_ISSUE:  if (r_cnt == '0) w_state_nxt = S_FETCH;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Beat qualifiers come straight from the held instruction word and the down-counter.
  logic w_beat, w_last, w_first;
  always_comb begin
    w_beat   = (r_state == S_ISSUE) && !stall;
    w_last   = (r_cnt == '0);
    w_first  = (r_cnt == w_rpt);
    valid    = w_beat;
    write_en = w_beat && (w_is_exec || (w_is_dot && w_last));
    r_select = w_beat && w_is_dot && w_last;
    dot_ctrl = DOT_NONE;
    if (w_beat && w_is_dot) begin
      if (w_last)       dot_ctrl = DOT_LAST;
      else if (w_first) dot_ctrl = DOT_FIRST;
      else              dot_ctrl = DOT_ACC;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc         <= '0;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_r          <= '0;
      r_pe_op      <= '0;
`ifdef SEQ_LOOP_EN
      r_loop_start <= '0;
      r_loop_cnt   <= '0;
`endif
    end else if (!stall) begin
      case (r_state)
        S_IDLE: if (start) r_pc <= start_pc;
        S_DECODE: begin
          if (w_is_exec || w_is_dot) begin
            r_cnt   <= w_rpt;
            r_a     <= w_ins[A_LSB +: ADDR_WIDTH];
            r_b     <= w_ins[B_LSB +: ADDR_WIDTH];
            r_r     <= w_ins[R_LSB +: ADDR_WIDTH];
            r_pe_op <= w_ins[PE_LSB +: OP_SEL_WIDTH];
          end else if (w_is_jump) begin
            r_pc <= w_ins[A_LSB +: INS_ADDR_WIDTH];
`ifdef SEQ_LOOP_EN
          end else if (w_opc == OPCODE_WIDTH'(OPC_LOOP)) begin
            r_loop_start <= r_pc + 1'b1;
            r_loop_cnt   <= w_rpt;
            r_pc         <= r_pc + 1'b1;
          end else if (w_opc == OPCODE_WIDTH'(OPC_ENDL)) begin
            if (r_loop_cnt != '0) begin
              r_loop_cnt <= r_loop_cnt - 1'b1;
              r_pc       <= r_loop_start;
            end else begin
              r_pc <= r_pc + 1'b1;
            end
`endif
          end else if (!w_is_halt) begin
            r_pc <= r_pc + 1'b1;
          end
        end
        S_ISSUE: begin
          if (r_cnt == '0) begin
            r_pc <= r_pc + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            r_a   <= r_a + 1'b1;
            r_b   <= r_b + 1'b1;
            if (w_is_exec) r_r <= r_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_done <= 1'b0;
    else       r_done <= (r_state == S_DECODE) && w_is_halt && !stall;
  end

  assign a_addr = r_a;
  assign b_addr = r_b;
  assign r_addr = r_r;
  assign pe_op  = r_pe_op;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;

endmodule
